// File: rtl/uart_sender_pkg.sv
// Shared constants and state encoding for the 8N1 UART transmitter.
// Imported by the sender, its baud generator and the bench.
package uart_sender_pkg;

  localparam int CLKS_PER_BIT_DEF = 5208;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and
// pulses bit_tick on the last cycle of every bit.
module uart_baud_gen
  import uart_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  assign bit_tick = !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_sender.sv
// 8N1 UART transmitter with a one-byte holding register so that
// consecutive frames can go out with no idle gap between them.
module uart_sender
  import uart_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done
);

  state_t     state;
  state_t     state_n;
  logic [2:0] idx;
  logic [2:0] idx_n;
  logic [7:0] shift;
  logic [7:0] shift_n;
  logic [7:0] hold;
  logic [7:0] hold_n;
  logic       hold_valid;
  logic       hold_valid_n;
  logic       tx_n;
  logic       bit_tick;
  logic       accept;
  logic       frame_end;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .bit_tick(bit_tick)
  );

  assign tx_ready  = !hold_valid;
  assign accept    = tx_start && tx_ready;
  assign frame_end = (state == STOP) && bit_tick;
  assign tx_done   = frame_end;
  assign tx_busy   = (state != IDLE);

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    shift_n      = shift;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    tx_n         = tx;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shift_n = tx_data;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_tick) begin
          tx_n    = shift[0];
          idx_n   = 3'd0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            idx_n   = idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (hold_valid) begin
            shift_n      = hold;
            hold_n       = '0;
            hold_valid_n = 1'b0;
            tx_n         = 1'b0;
            state_n      = START;
          end else if (accept) begin
            shift_n = tx_data;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Mid-frame accepts park in the hold; the stop-bit edge bypasses it.
    if (accept && (state != IDLE) && !frame_end) begin
      hold_n       = tx_data;
      hold_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shift      <= shift_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      tx         <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender at 4 clocks per bit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_sender;
  import uart_sender_pkg::*;

  localparam int CPB = 4;
  localparam int FL  = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_sender #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    if (k == FRAME_BITS - 1) return 1'b1;
    return b[k-1];
  endfunction

  // Called on frame cycle 0 (first tx=0 sample); ends on cycle 40.
  task automatic frame(input logic [7:0] b, input int rdy_from,
                       input int keep_n,
                       input int o1, input logic [7:0] d1,
                       input int o2, input logic [7:0] d2);
    for (int c = 0; c < FL; c++) begin
      tx_start = (c < keep_n) || (c == o1) || (c == o2);
      if (c == o1) tx_data = d1;
      else if (c == o2) tx_data = d2;
      chk($sformatf("%02h tx c%0d", b, c), 8'(tx), 8'(fbit(b, c)));
      chk($sformatf("%02h busy c%0d", b, c), 8'(tx_busy), 8'd1);
      chk($sformatf("%02h done c%0d", b, c), 8'(tx_done),
          8'(c == FL - 1));
      chk($sformatf("%02h ready c%0d", b, c), 8'(tx_ready),
          8'((rdy_from < 0) || (c < rdy_from)));
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    tx_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("idle tx", 8'(tx), 8'd1);
      chk("idle busy", 8'(tx_busy), 8'd0);
      chk("idle done", 8'(tx_done), 8'd0);
      chk("idle ready", 8'(tx_ready), 8'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    tx_start = 1'b0;
    tx_data  = 8'h00;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst tx", 8'(tx), 8'd1);
    chk("rst busy", 8'(tx_busy), 8'd0);
    chk("rst done", 8'(tx_done), 8'd0);
    chk("rst ready", 8'(tx_ready), 8'd1);
    rst_n = 1'b1;
    idle(3);

    // single frame
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk);
    frame(8'hA5, -1, 0, -1, 8'h00, -1, 8'h00);
    idle(3);

    // second byte held, back-to-back frames
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clk);
    frame(8'h3C, 5, 0, 4, 8'hC3, -1, 8'h00);
    frame(8'hC3, -1, 0, -1, 8'h00, -1, 8'h00);
    idle(3);

    // third offer while hold full is dropped
    tx_start = 1'b1;
    tx_data  = 8'h11;
    @(negedge clk);
    frame(8'h11, 3, 0, 2, 8'h22, 10, 8'h33);
    frame(8'h22, -1, 0, -1, 8'h00, -1, 8'h00);
    idle(50);

    // offer on the last stop cycle bypasses the hold
    tx_start = 1'b1;
    tx_data  = 8'h81;
    @(negedge clk);
    frame(8'h81, -1, 0, 39, 8'h7E, -1, 8'h00);
    frame(8'h7E, -1, 0, -1, 8'h00, -1, 8'h00);
    idle(3);

    // tx_start held high for 100 cycles
    tx_start = 1'b1;
    tx_data  = 8'h0F;
    @(negedge clk);
    frame(8'h0F, 1, FL, -1, 8'h00, -1, 8'h00);
    frame(8'h0F, 1, FL, -1, 8'h00, -1, 8'h00);
    frame(8'h0F, 1, 19, -1, 8'h00, -1, 8'h00);
    frame(8'h0F, -1, 0, -1, 8'h00, -1, 8'h00);
    idle(3);

    // reset mid-frame with a byte held
    tx_start = 1'b1;
    tx_data  = 8'h55;
    @(negedge clk);
    for (int c = 0; c < 17; c++) begin
      tx_start = (c == 2);
      if (c == 2) tx_data = 8'hAA;
      chk($sformatf("55 tx c%0d", c), 8'(tx), 8'(fbit(8'h55, c)));
      @(negedge clk);
    end
    chk("pre-rst ready", 8'(tx_ready), 8'd0);
    chk("pre-rst tx", 8'(tx), 8'd0);
    rst_n = 1'b0;
    #1;
    chk("abort tx", 8'(tx), 8'd1);
    chk("abort busy", 8'(tx_busy), 8'd0);
    chk("abort done", 8'(tx_done), 8'd0);
    chk("abort ready", 8'(tx_ready), 8'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(50);

    // first send after reset
    tx_start = 1'b1;
    tx_data  = 8'h96;
    @(negedge clk);
    frame(8'h96, -1, 0, -1, 8'h00, -1, 8'h00);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208 (50 MHz / 9600 baud), clock cycles per serial bit, legal range 2..65535.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tx_start  input  1  request to send tx_data, sampled each clk edge.
REQ-005 tx_data  input  8  byte to send (CPU result byte), sampled when tx_start & tx_ready.
REQ-006 tx  output  1  serial line; 8N1 format, LSB first, idle high.
REQ-007 tx_ready  output  1  high when the one-entry holding register is empty and tx_start will be accepted.
REQ-008 tx_busy  output  1  high while a frame (start, data or stop bit) is on the line.
REQ-009 tx_done  output  1  one-cycle pulse in the last clk of each stop bit.

Function
REQ-010 States: IDLE, START, DATA, STOP; state register plus 3-bit bit index, 16-bit baud counter, 8-bit shift register, 8-bit holding register with valid flag.
REQ-011 Accept = tx_start & tx_ready; when tx_ready is low, tx_start is ignored and no byte is lost or duplicated.
REQ-012 Accept in IDLE: byte loads directly into the shift register; next cycle state START, tx=0, tx_busy=1, tx_ready stays 1.
REQ-013 Accept while not IDLE (except REQ-018): byte goes to the holding register; tx_ready=0 from the next cycle.
REQ-014 Each of START, every DATA bit and STOP lasts exactly CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0 on each bit boundary.
REQ-015 DATA drives shift[0] for bit index 0..7, shifting right at each bit boundary; after bit 7, go to STOP with tx=1.
REQ-016 Frame length is 10*CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the cycle after the tx_done pulse.
REQ-017 STOP end with hold valid: the held byte moves to the shift register, state goes directly to START (no idle gap), hold is cleared, and tx_ready=1 the next cycle.
REQ-018 STOP end with hold empty and accept in the same cycle: bypass into the shift register, behaving as REQ-017.
REQ-019 STOP end with nothing pending: state goes to IDLE, tx=1, tx_busy=0 the next cycle.
REQ-020 tx is registered; no combinational path from any input to tx.
REQ-021 tx_done is high for exactly one cycle per frame, including back-to-back frames.

Reset
REQ-022 While rst_n=0: tx=1, tx_busy=0, tx_done=0, tx_ready=1, state IDLE, all counters and registers 0, hold invalid.
REQ-023 Reset asserted mid-frame aborts the frame immediately (tx=1 asynchronously), discards the held byte, and emits no tx_done.
REQ-024 After rst_n rises, the first accepted tx_start behaves per REQ-012.

Structure
REQ-025 A shared package holds the CLKS_PER_BIT default, the state encoding constants, and the frame bit count (10).
REQ-026 One sub-module, uart_baud_gen, provides the baud counter with a clear input and a bit_tick output that pulses on the last cycle of each bit; uart_sender instantiates it once.

Verification (CLKS_PER_BIT=4)
REQ-027 Idle, tx_start with 0xA5 -> tx = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles; tx_done after 40 cycles; tx_busy high for 40 cycles.
REQ-028 0x3C accepted, then 0xC3 accepted 5 cycles later -> tx_ready low until the first STOP ends; the second frame's start bit follows the first stop bit with no idle cycle; two tx_done pulses 40 cycles apart.
REQ-029 Third tx_start while hold full (0x11 sending, 0x22 held, 0x33 offered) -> 0x33 ignored; only 0x11 and 0x22 appear on tx.
REQ-030 tx_start with 0x7E in the final STOP cycle of 0x81, hold empty -> 0x7E start bit begins on the next cycle (bypass); tx_ready never drops.
REQ-031 rst_n low at cycle 17 of a 0x55 frame with 0xAA held -> tx=1 at once, no tx_done; after release, tx stays idle-high until a new tx_start.
REQ-032 tx_start held high continuously for 100 cycles with a constant 0x0F -> back-to-back 0x0F frames, tx_done pulses every 40 cycles, and the hold register is never overwritten while full.
